// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives a request/ack data memory port with timeout,
// resolves PC source, and registers the MEM/WB slot.
module mem_access_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [1:0]  i_wb,
    input  logic        i_branch,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic        i_zf,
    input  logic        i_jump,
    input  logic [31:0] i_add_res,
    input  logic [31:0] i_alu_res,
    input  logic [31:0] i_datwri_mem,
    input  logic [4:0]  i_addr_reg_wri,
    input  logic [31:0] i_ins32_j,
    output logic        o_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  o_pcsrc,
    output logic [31:0] o_pc_target,
    output logic [1:0]  o_wb,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_res,
    output logic [4:0]  o_addr_reg_wri,
    output logic        o_valid,
    output logic        o_mem_err
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   alu_q;
    logic [4:0]    rd_q;
    logic [1:0]    wb_q;

    logic is_mem, bad_mem, start, timeout;

    assign is_mem  = i_memread | i_memwrite;
    assign bad_mem = (i_memread & i_memwrite) | (i_alu_res[1:0] != 2'b00);
    assign start   = (state == IDLE) & i_valid & is_mem & ~bad_mem;
    assign timeout = (state == ACCESS) & ~mem_ack & (cnt == LAST);
    assign o_stall = start | ((state == ACCESS) & ~mem_ack);

    // PC redirect only from a valid slot that is not frozen; jump outranks branch.
    always_comb begin
        o_pcsrc     = 2'b00;
        o_pc_target = 32'h0;
        if (rst_n && i_valid && !o_stall) begin
            if (i_jump) begin
                o_pcsrc     = 2'b10;
                o_pc_target = i_ins32_j;
            end else if (i_branch && i_zf) begin
                o_pcsrc     = 2'b01;
                o_pc_target = i_add_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            alu_q          <= '0;
            rd_q           <= '0;
            wb_q           <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            o_wb           <= '0;
            o_read_data    <= '0;
            o_alu_res      <= '0;
            o_addr_reg_wri <= '0;
            o_valid        <= 1'b0;
            o_mem_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            o_mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    o_read_data    <= '0;
                    o_alu_res      <= i_alu_res;
                    o_addr_reg_wri <= i_addr_reg_wri;
                    if (!i_valid) begin
                        o_valid <= 1'b0;
                        o_wb    <= '0;
                    end else if (!is_mem) begin
                        o_valid <= 1'b1;
                        o_wb    <= i_wb;
                    end else if (bad_mem) begin
                        o_valid   <= 1'b1;
                        o_wb      <= {i_wb[1], 1'b0};
                        o_mem_err <= 1'b1;
                    end else begin
                        state     <= ACCESS;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= i_memwrite;
                        mem_addr  <= {i_alu_res[31:2], 2'b00};
                        mem_wdata <= i_datwri_mem;
                        alu_q     <= i_alu_res;
                        rd_q      <= i_addr_reg_wri;
                        wb_q      <= i_wb;
                        o_valid   <= 1'b0;
                        o_wb      <= '0;
                    end
                end
                ACCESS: begin
                    if (mem_ack || timeout) begin
                        state          <= IDLE;
                        mem_req        <= 1'b0;
                        mem_we         <= 1'b0;
                        o_valid        <= 1'b1;
                        o_alu_res      <= alu_q;
                        o_addr_reg_wri <= rd_q;
                        // Ack wins over a simultaneous timeout.
                        if (mem_ack) begin
                            o_wb        <= wb_q;
                            o_read_data <= mem_we ? 32'h0 : mem_rdata;
                        end else begin
                            o_wb        <= {wb_q[1], 1'b0};
                            o_read_data <= '0;
                            o_mem_err   <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        o_valid <= 1'b0;
                        o_wb    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYC = 16).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_branch, i_memread, i_memwrite, i_zf, i_jump;
    logic [1:0]  i_wb;
    logic [31:0] i_add_res, i_alu_res, i_datwri_mem, i_ins32_j;
    logic [4:0]  i_addr_reg_wri;
    logic        o_stall, mem_req, mem_we, mem_ack, o_valid, o_mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, o_pc_target, o_read_data, o_alu_res;
    logic [1:0]  o_pcsrc, o_wb;
    logic [4:0]  o_addr_reg_wri;

    int checks = 0;
    int failures = 0;
    int n;

    mem_access_unit #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_wb(i_wb),
        .i_branch(i_branch), .i_memread(i_memread), .i_memwrite(i_memwrite),
        .i_zf(i_zf), .i_jump(i_jump), .i_add_res(i_add_res), .i_alu_res(i_alu_res),
        .i_datwri_mem(i_datwri_mem), .i_addr_reg_wri(i_addr_reg_wri),
        .i_ins32_j(i_ins32_j), .o_stall(o_stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .o_pcsrc(o_pcsrc),
        .o_pc_target(o_pc_target), .o_wb(o_wb), .o_read_data(o_read_data),
        .o_alu_res(o_alu_res), .o_addr_reg_wri(o_addr_reg_wri),
        .o_valid(o_valid), .o_mem_err(o_mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        i_valid = 0; i_branch = 0; i_memread = 0; i_memwrite = 0; i_zf = 0; i_jump = 0;
        i_wb = 2'b00; i_add_res = 0; i_alu_res = 0; i_datwri_mem = 0; i_ins32_j = 0;
        i_addr_reg_wri = 0;
    endtask

    task automatic load_in(input logic [31:0] addr, input logic [4:0] rd);
        clear_in();
        i_valid = 1; i_memread = 1; i_wb = 2'b11; i_alu_res = addr; i_addr_reg_wri = rd;
    endtask

    initial begin
        clear_in();
        mem_ack = 0; mem_rdata = 0;
        rst_n = 0;
        i_valid = 1; i_jump = 1; i_ins32_j = 32'h400;
        #3;
        check("rst_valid", o_valid, 0);
        check("rst_wb", o_wb, 0);
        check("rst_req", mem_req, 0);
        check("rst_err", o_mem_err, 0);
        check("rst_pcsrc", o_pcsrc, 0);
        check("rst_rdata", o_read_data, 0);
        clear_in();
        @(negedge clk) rst_n = 1;
        step();

        // Plain ALU instruction
        i_valid = 1; i_wb = 2'b01; i_alu_res = 32'h55; i_addr_reg_wri = 5'd3;
        #1 check("alu_stall", o_stall, 0);
        step();
        check("alu_valid", o_valid, 1);
        check("alu_wb", o_wb, 2'b01);
        check("alu_res", o_alu_res, 32'h55);
        check("alu_rd", o_addr_reg_wri, 3);
        check("alu_rdata", o_read_data, 0);

        // Load, ack on third ACCESS cycle
        load_in(32'h100, 5'd5);
        #1 check("ld_stall_idle", o_stall, 1);
        check("ld_pcsrc_idle", o_pcsrc, 0);
        step();
        check("ld_bubble", o_valid, 0);
        i_alu_res = 32'hFFC; i_addr_reg_wri = 5'd9; i_wb = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
            #1;
            check($sformatf("ld_req_c%0d", k), mem_req, 1);
            check($sformatf("ld_addr_c%0d", k), mem_addr, 32'h100);
            check($sformatf("ld_we_c%0d", k), mem_we, 0);
            check($sformatf("ld_stall_c%0d", k), o_stall, (k != 3));
            step();
        end
        mem_ack = 0; clear_in();
        check("ld_rdata", o_read_data, 32'hDEADBEEF);
        check("ld_valid", o_valid, 1);
        check("ld_wb", o_wb, 2'b11);
        check("ld_alu", o_alu_res, 32'h100);
        check("ld_rd", o_addr_reg_wri, 5);
        check("ld_req_off", mem_req, 0);
        check("ld_err", o_mem_err, 0);
        step();

        // Store, immediate ack
        i_valid = 1; i_memwrite = 1; i_wb = 2'b00; i_alu_res = 32'h20; i_datwri_mem = 32'h12345678;
        step();
        clear_in();
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 32'h12345678);
        check("st_addr", mem_addr, 32'h20);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        #1 check("st_stall_ack", o_stall, 0);
        step();
        mem_ack = 0;
        check("st_rdata", o_read_data, 0);
        check("st_err", o_mem_err, 0);
        check("st_valid", o_valid, 1);

        // Timeout with no ack
        load_in(32'h40, 5'd7);
        step();
        clear_in();
        n = 0;
        while (mem_req && n < 40) begin n++; step(); end
        check("to_req_cycles", n, 16);
        check("to_err", o_mem_err, 1);
        check("to_wb", o_wb, 2'b10);
        check("to_valid", o_valid, 1);
        check("to_rdata", o_read_data, 0);
        step();
        check("to_err_pulse", o_mem_err, 0);

        // Ack on the 16th ACCESS cycle wins over timeout
        load_in(32'h44, 5'd8);
        step();
        clear_in();
        for (int k = 0; k < 15; k++) step();
        check("ack16_req", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'hCAFE0001;
        #1 check("ack16_stall", o_stall, 0);
        step();
        mem_ack = 0;
        check("ack16_err", o_mem_err, 0);
        check("ack16_rdata", o_read_data, 32'hCAFE0001);
        check("ack16_wb", o_wb, 2'b11);

        // Misaligned read, then read+write together
        load_in(32'h102, 5'd2);
        #1 check("mis_stall", o_stall, 0);
        step();
        check("mis_req", mem_req, 0);
        check("mis_err", o_mem_err, 1);
        check("mis_wb0", o_wb[0], 0);
        check("mis_valid", o_valid, 1);
        load_in(32'h8, 5'd2);
        i_memwrite = 1;
        step();
        clear_in();
        check("rw_req", mem_req, 0);
        check("rw_err", o_mem_err, 1);
        check("rw_wb0", o_wb[0], 0);

        // Stray ack while idle
        mem_ack = 1; mem_rdata = 32'h1234;
        step();
        mem_ack = 0;
        check("idle_ack_valid", o_valid, 0);
        check("idle_ack_wb", o_wb, 0);
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_err", o_mem_err, 0);

        // Control flow
        i_valid = 1; i_jump = 1; i_ins32_j = 32'h400; i_add_res = 32'h800;
        #1 check("jmp_pcsrc", o_pcsrc, 2'b10);
        check("jmp_target", o_pc_target, 32'h400);
        i_branch = 1; i_zf = 1;
        #1 check("jmpbr_pcsrc", o_pcsrc, 2'b10);
        i_jump = 0;
        #1 check("br_pcsrc", o_pcsrc, 2'b01);
        check("br_target", o_pc_target, 32'h800);
        i_zf = 0;
        #1 check("br_nz_pcsrc", o_pcsrc, 2'b00);
        i_valid = 0; i_zf = 1;
        #1 check("br_invalid", o_pcsrc, 2'b00);
        i_valid = 1; i_memread = 1; i_alu_res = 32'h80;
        #1 check("br_stall_idle", o_pcsrc, 2'b00);
        check("br_stall_tgt", o_pc_target, 0);
        step();
        check("br_stall_acc", o_pcsrc, 2'b00);
        mem_ack = 1;
        #1 check("br_after_stall", o_pcsrc, 2'b01);
        step();
        mem_ack = 0; clear_in();
        step();

        // Reset during ACCESS
        load_in(32'h200, 5'd4);
        step();
        check("rm_req_before", mem_req, 1);
        #2 rst_n = 0;
        #1;
        check("rm_req", mem_req, 0);
        check("rm_addr", mem_addr, 0);
        check("rm_valid", o_valid, 0);
        check("rm_alu", o_alu_res, 0);
        @(negedge clk) rst_n = 1;
        step();
        check("rm_restart_req", mem_req, 1);
        check("rm_restart_addr", mem_addr, 32'h200);
        clear_in();
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_ack = 0;
        check("rm_rdata", o_read_data, 32'hA5A5A5A5);
        check("rm_done_valid", o_valid, 1);
        check("rm_done_rd", o_addr_reg_wri, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
